z80_bus_responder: RTL and testbench

- Target side of the Z80 bus driven by the tv80s-based CPU wrapper.
- Decodes mreq_n/iorq_n/rd_n/wr_n and forwards memory cycles to the DRAM/video memory arbiter over a req/ack handshake, stretching the CPU with wait_n until the arbiter acknowledges.
- Implements the ULA port (A0=0): border, beeper, MIC, keyboard and EAR.
- Ignores writes to the ROM region.

---
 rtl/z80_bus_responder.sv | 133 +++++++++++++
 tb/tb_z80_bus_responder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_responder.sv
// Z80 bus target: memory cycles go to the arbiter over req/ack,
// ULA port 0xFE handled locally, ROM writes dropped.
module z80_bus_responder #(
    parameter logic [15:0] ROM_TOP     = 16'h3FFF,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic        wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  kbd_row,
    input  logic [4:0]  kbd_cols,
    input  logic        ear_in,
    output logic [2:0]  border,
    output logic        beeper,
    output logic        mic,
    output logic        timeout_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          strobe;
    logic          is_mem;
    logic          is_io;
    logic          is_wr;
    logic          rom_hit;
    logic          expire;

    assign strobe  = !rd_n || !wr_n;
    assign is_mem  = !mreq_n && iorq_n;
    assign is_io   = mreq_n && !iorq_n;
    assign is_wr   = !wr_n;
    assign rom_hit = cpu_addr <= ROM_TOP;
    assign cnt_nxt = cnt + 1'b1;
    assign expire  = cnt_nxt == CW'(ACK_TIMEOUT);

    // Bus FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wait_n      <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 8'h00;
            cpu_din     <= 8'hFF;
            kbd_row     <= 8'hFF;
            border      <= 3'b000;
            beeper      <= 1'b0;
            mic         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (strobe && (is_mem || is_io)) begin
                        if (is_mem && !(is_wr && rom_hit)) begin
                            state     <= MEM;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_wr;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_dout;
                            wait_n    <= 1'b0;
                        end else begin
                            state <= HOLD;
                            if (is_io && !cpu_addr[0]) begin
                                if (is_wr) begin
                                    border <= cpu_dout[2:0];
                                    mic    <= cpu_dout[3];
                                    beeper <= cpu_dout[4];
                                end else begin
                                    cpu_din <= {1'b1, ear_in,
                                                1'b1, kbd_cols};
                                    kbd_row <= cpu_addr[15:8];
                                end
                            end else if (is_io && !is_wr) begin
                                cpu_din <= 8'hFF;
                            end
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            cpu_din <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        wait_n  <= 1'b1;
                        state   <= HOLD;
                    end else if (expire) begin
                        mem_req     <= 1'b0;
                        wait_n      <= 1'b1;
                        timeout_err <= 1'b1;
                        cpu_din     <= 8'hFF;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                HOLD: begin
                    if (rd_n && wr_n) begin
                        state   <= IDLE;
                        kbd_row <= 8'hFF;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: transaction-level model
// of expected outputs, checked every cycle, plus literal pins.
module tb_z80_bus_responder;

    localparam logic [15:0] ROM = 16'h3FFF;
    localparam int          ACK_TO = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        mreq_n, iorq_n, rd_n, wr_n;
    logic        wait_n;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  kbd_row;
    logic [4:0]  kbd_cols;
    logic        ear_in;
    logic [2:0]  border;
    logic        beeper, mic, timeout_err;

    z80_bus_responder #(
        .ROM_TOP    (ROM),
        .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .mreq_n     (mreq_n),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .wait_n     (wait_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .kbd_row    (kbd_row),
        .kbd_cols   (kbd_cols),
        .ear_in     (ear_in),
        .border     (border),
        .beeper     (beeper),
        .mic        (mic),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // expected architectural state of the responder
    logic [7:0]  exp_cpu_din;
    logic        exp_wait_n, exp_mem_req, exp_mem_we;
    logic [15:0] exp_mem_addr;
    logic [7:0]  exp_mem_wdata, exp_kbd_row;
    logic [2:0]  exp_border;
    logic        exp_beeper, exp_mic, exp_timeout;

    int n_total = 0;
    int n_pass  = 0;
    int wlow    = 0;
    int rises   = 0;
    logic req_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] ula_in(input logic [4:0] c,
                                          input logic e);
        return {1'b1, e, 1'b1, c};
    endfunction

    task automatic set_reset_exp();
        exp_cpu_din   = 8'hFF;
        exp_wait_n    = 1'b1;
        exp_mem_req   = 1'b0;
        exp_mem_we    = 1'b0;
        exp_mem_addr  = 16'h0000;
        exp_mem_wdata = 8'h00;
        exp_kbd_row   = 8'hFF;
        exp_border    = 3'b000;
        exp_beeper    = 1'b0;
        exp_mic       = 1'b0;
        exp_timeout   = 1'b0;
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("cpu_din", cpu_din, exp_cpu_din);
        chk("wait_n", wait_n, exp_wait_n);
        chk("mem_req", mem_req, exp_mem_req);
        chk("kbd_row", kbd_row, exp_kbd_row);
        chk("border", border, exp_border);
        chk("beeper", beeper, exp_beeper);
        chk("mic", mic, exp_mic);
        chk("timeout_err", timeout_err, exp_timeout);
        if (exp_mem_req) begin
            chk("mem_we", mem_we, exp_mem_we);
            chk("mem_addr", mem_addr, exp_mem_addr);
            chk("mem_wdata", mem_wdata, exp_mem_wdata);
        end
        if (wait_n === 1'b0) wlow++;
        if (mem_req === 1'b1 && !req_prev) rises++;
        req_prev = mem_req;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // d = write data, or read data the arbiter returns;
    // acks = idle arbiter cycles before ack, -1 = never ack
    task automatic mem_cyc(input logic [15:0] a, input logic we,
                           input logic [7:0] d, input int acks,
                           input int extra);
        cpu_addr = a;
        cpu_dout = we ? d : 8'h77;
        mreq_n   = 1'b0;
        rd_n     = we;
        wr_n     = !we;
        step();
        if (!we || a > ROM) begin
            exp_mem_req   = 1'b1;
            exp_wait_n    = 1'b0;
            exp_mem_we    = we;
            exp_mem_addr  = a;
            exp_mem_wdata = cpu_dout;
            if (acks < 0) begin
                repeat (ACK_TO - 1) step();
                step();
                exp_timeout = 1'b1;
                exp_cpu_din = 8'hFF;
            end else begin
                repeat (acks) step();
                mem_ack   = 1'b1;
                mem_rdata = we ? 8'hEE : d;
                step();
                mem_ack   = 1'b0;
                mem_rdata = 8'h00;
                if (!we) exp_cpu_din = d;
            end
            exp_mem_req = 1'b0;
            exp_wait_n  = 1'b1;
        end
        repeat (extra) step();
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        step();
    endtask

    task automatic io_start(input logic [15:0] a, input logic we,
                            input logic [7:0] d);
        cpu_addr = a;
        cpu_dout = d;
        iorq_n   = 1'b0;
        rd_n     = we;
        wr_n     = !we;
        step();
        if (!a[0]) begin
            if (we) begin
                exp_border = d[2:0];
                exp_mic    = d[3];
                exp_beeper = d[4];
            end else begin
                exp_cpu_din = ula_in(kbd_cols, ear_in);
                exp_kbd_row = a[15:8];
            end
        end else if (!we) begin
            exp_cpu_din = 8'hFF;
        end
    endtask

    task automatic io_end();
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        step();
        exp_kbd_row = 8'hFF;
    endtask

    int w0, r0;

    initial begin
        reset_n   = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_dout  = 8'h00;
        mreq_n    = 1'b1;
        iorq_n    = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        kbd_cols  = 5'b11111;
        ear_in    = 1'b1;
        set_reset_exp();
        #7;
        chk("rst_cpu_din", cpu_din, 8'hFF);
        chk("rst_wait_n", wait_n, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_kbd_row", kbd_row, 8'hFF);
        step();
        reset_n = 1'b1;
        step();

        // read 0x8000, ack after 3 idle cycles
        w0 = wlow; r0 = rises;
        mem_cyc(16'h8000, 1'b0, 8'hA5, 3, 0);
        chk("rd_wait_cycles", wlow - w0, 4);
        chk("rd_requests", rises - r0, 1);
        chk("rd_cpu_din", cpu_din, 8'hA5);

        // write 0x4000 with strobes held 5 extra cycles
        w0 = wlow; r0 = rises;
        mem_cyc(16'h4000, 1'b1, 8'h3C, 1, 5);
        chk("wr_wait_cycles", wlow - w0, 2);
        chk("wr_requests", rises - r0, 1);
        chk("wr_cpu_din_kept", cpu_din, 8'hA5);

        // ROM write dropped, then a normal read of same address
        w0 = wlow; r0 = rises;
        mem_cyc(16'h1234, 1'b1, 8'h99, 0, 2);
        chk("rom_wr_wait", wlow - w0, 0);
        chk("rom_wr_requests", rises - r0, 0);
        r0 = rises;
        mem_cyc(16'h1234, 1'b0, 8'h5A, 0, 0);
        chk("rom_rd_requests", rises - r0, 1);

        // ULA port
        io_start(16'h00FE, 1'b1, 8'h15);
        chk("out_border", border, 3'b101);
        chk("out_beeper", beeper, 1'b1);
        chk("out_mic", mic, 1'b0);
        io_end();
        kbd_cols = 5'b11110;
        ear_in   = 1'b0;
        io_start(16'hFEFE, 1'b0, 8'h00);
        chk("in_kbd_row", kbd_row, 8'hFE);
        chk("in_cpu_din", cpu_din, 8'hBE);
        io_end();
        chk("in_kbd_row_idle", kbd_row, 8'hFF);
        io_start(16'h00FF, 1'b0, 8'h00);
        chk("in_odd_port", cpu_din, 8'hFF);
        io_end();

        // both mreq_n and iorq_n low: no cycle
        r0 = rises;
        cpu_addr = 16'h9000;
        mreq_n = 1'b0;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        repeat (3) step();
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        step();
        chk("both_low_requests", rises - r0, 0);

        // arbiter never acks
        w0 = wlow;
        mem_cyc(16'hC000, 1'b0, 8'h11, -1, 0);
        chk("to_wait_cycles", wlow - w0, ACK_TO);
        chk("to_err", timeout_err, 1'b1);
        chk("to_cpu_din", cpu_din, 8'hFF);
        mem_cyc(16'h8001, 1'b0, 8'hC3, 2, 0);
        chk("after_to_din", cpu_din, 8'hC3);

        // reset in the middle of a memory cycle
        cpu_addr = 16'h9000;
        cpu_dout = 8'h00;
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        step();
        exp_mem_req   = 1'b1;
        exp_wait_n    = 1'b0;
        exp_mem_we    = 1'b0;
        exp_mem_addr  = 16'h9000;
        exp_mem_wdata = 8'h00;
        step();
        step();
        #1;
        reset_n = 1'b0;
        set_reset_exp();
        #1;
        chk("async_mem_req", mem_req, 1'b0);
        chk("async_wait_n", wait_n, 1'b1);
        chk("async_border", border, 3'b000);
        chk("async_timeout", timeout_err, 1'b0);
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        step();
        mem_ack   = 1'b0;
        step();
        chk("late_ack_din", cpu_din, 8'hFF);
        chk("late_ack_req", mem_req, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
